// File: rtl/alu_pkg.sv
// alu_pkg: shared mode/state encodings and common Hack control words
package alu_pkg;
  typedef enum logic [1:0] {MODE_HACK = 2'b00, MODE_MUL = 2'b01, MODE_SHL = 2'b10, MODE_SRA = 2'b11} mode_t;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  localparam logic [5:0] C_ZERO = 6'b101010;
  localparam logic [5:0] C_XPLUSY = 6'b000010;
  localparam logic [5:0] C_XMINUSY = 6'b010011;
endpackage

// File: rtl/alu_pipe_if.sv
// alu_pipe_if: command and result handshake bundle for alu_pipe
interface alu_pipe_if #(parameter int WIDTH = 16) ();
  logic in_valid, in_ready, out_valid, out_ready, zr, ng, co;
  logic [WIDTH-1:0] x, y, out;
  logic [5:0] ctrl;
  logic [1:0] mode;
  modport master (output in_valid, x, y, ctrl, mode, out_ready, input in_ready, out_valid, out, zr, ng, co);
  modport slave (input in_valid, x, y, ctrl, mode, out_ready, output in_ready, out_valid, out, zr, ng, co);
endinterface

// File: rtl/hack_core.sv
// hack_core: combinational Hack ALU function with adder carry-out
module hack_core #(parameter int WIDTH = 16) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [5:0]       ctrl,
  output logic [WIDTH-1:0] out,
  output logic             co
);
  logic [WIDTH-1:0] xz, yz, xa, ya, r;
  logic [WIDTH:0] s;
  assign xz = ctrl[5] ? '0 : x;
  assign xa = ctrl[4] ? ~xz : xz;
  assign yz = ctrl[3] ? '0 : y;
  assign ya = ctrl[2] ? ~yz : yz;
  assign s = {1'b0, xa} + {1'b0, ya};
  assign r = ctrl[1] ? s[WIDTH-1:0] : xa & ya;
  assign out = ctrl[0] ? ~r : r;
  // carry is taken before the final inversion
  assign co = ctrl[1] & s[WIDTH];
endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: handshaked Hack ALU with multi-cycle multiply and shift modes
module alu_pipe import alu_pkg::*; #(
  parameter int WIDTH = 16,
  parameter int CW = $clog2(WIDTH) + 1
) (
  input logic clk,
  input logic reset,
  alu_pipe_if.slave bus
);
  localparam logic [CW-1:0] WC = CW'(WIDTH);
  localparam logic [WIDTH-1:0] WY = WIDTH'(WIDTH);
  state_t state;
  mode_t md;
  logic [WIDTH-1:0] a, b, m, nxt, res, h_out;
  logic [CW-1:0] cnt, n;
  logic h_co, load;
  hack_core #(.WIDTH(WIDTH)) core (.x(bus.x), .y(bus.y), .ctrl(bus.ctrl), .out(h_out), .co(h_co));
  assign bus.in_ready = state == S_IDLE;
  assign bus.out_valid = state == S_DONE;
  always_comb begin
    n = bus.y >= WY ? WC : bus.y[CW-1:0];
    nxt = md == MODE_MUL ? a + (b[0] ? m : '0) : md == MODE_SHL ? a << 1 : {a[WIDTH-1], a[WIDTH-1:1]};
    res = state == S_RUN ? nxt : bus.mode == MODE_HACK ? h_out : bus.x;
    // single-cycle paths (HACK, zero-length shift) finish straight from IDLE
    load = state == S_RUN ? cnt == CW'(1)
         : state == S_IDLE && bus.in_valid && (bus.mode == MODE_HACK || (bus.mode != MODE_MUL && n == '0));
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      md <= MODE_HACK;
      cnt <= '0;
      a <= '0;
      b <= '0;
      m <= '0;
      bus.out <= '0;
      bus.zr <= 1'b0;
      bus.ng <= 1'b0;
      bus.co <= 1'b0;
    end else begin
      if (load) begin
        bus.out <= res;
        bus.zr <= res == '0;
        bus.ng <= res[WIDTH-1];
        bus.co <= state == S_IDLE && bus.mode == MODE_HACK && h_co;
      end
      case (state)
        S_IDLE: if (bus.in_valid) begin
          md <= mode_t'(bus.mode);
          a <= bus.mode == MODE_MUL ? '0 : bus.x;
          m <= bus.x;
          b <= bus.y;
          cnt <= bus.mode == MODE_MUL ? WC : n;
          state <= load ? S_DONE : S_RUN;
        end
        S_RUN: begin
          a <= nxt;
          m <= m << 1;
          b <= b >> 1;
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) state <= S_DONE;
        end
        default: if (bus.out_ready) state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed and random checks of alu_pipe against an arithmetic model
module tb_alu_pipe;
  import alu_pkg::*;
  logic clk = 0, reset = 1;
  always #5 clk = ~clk;
  alu_pipe_if #(.WIDTH(16)) bus ();
  alu_pipe #(.WIDTH(16)) dut (.clk(clk), .reset(reset), .bus(bus));
  int errors = 0, checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model(input logic [1:0] md, input logic [15:0] x, input logic [15:0] y,
                                input logic [5:0] c, output logic [15:0] r, output logic cr, output int lat);
    int n;
    logic [15:0] xv, yv;
    logic [16:0] s;
    logic [31:0] p;
    n = (y > 16) ? 16 : int'(y);
    cr = 1'b0;
    case (md)
      MODE_HACK: begin
        xv = c[5] ? 16'd0 : x;
        if (c[4]) xv = ~xv;
        yv = c[3] ? 16'd0 : y;
        if (c[2]) yv = ~yv;
        s = xv + yv;
        r = c[1] ? s[15:0] : (xv & yv);
        if (c[0]) r = ~r;
        cr = c[1] & s[16];
        lat = 1;
      end
      MODE_MUL: begin
        p = x * y;
        r = p[15:0];
        lat = 17;
      end
      MODE_SHL: begin
        r = (n >= 16) ? 16'd0 : x << n;
        lat = n + 1;
      end
      default: begin
        r = 16'($signed(x) >>> n);
        lat = n + 1;
      end
    endcase
  endfunction

  task automatic run_op(input logic [1:0] md, input logic [15:0] x, input logic [15:0] y,
                        input logic [5:0] c, input bit hs, input string tag);
    logic [15:0] r;
    logic cr;
    int lat, exp_lat;
    model(md, x, y, c, r, cr, exp_lat);
    bus.mode = md; bus.x = x; bus.y = y; bus.ctrl = c; bus.in_valid = 1;
    @(posedge clk); #1 bus.in_valid = 0;
    lat = 1;
    check({tag, " in_ready_busy"}, bus.in_ready, 0);
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " out"}, bus.out, r);
    check({tag, " zr"}, bus.zr, r == 16'd0);
    check({tag, " ng"}, bus.ng, r[15]);
    check({tag, " co"}, bus.co, cr);
    if (hs) begin
      bus.out_ready = 1;
      @(posedge clk); #1 bus.out_ready = 0;
      check({tag, " in_ready_after"}, bus.in_ready, 1);
      check({tag, " out_valid_after"}, bus.out_valid, 0);
    end
  endtask

  initial begin
    logic [1:0] rm;
    logic [15:0] rx, ry;
    logic [5:0] rc;
    bit seen;
    bus.in_valid = 0; bus.out_ready = 0; bus.x = 0; bus.y = 0; bus.ctrl = 0; bus.mode = 0;
    repeat (3) @(posedge clk);
    #1 reset = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst in_ready", bus.in_ready, 1);
    check("rst out_valid", bus.out_valid, 0);
    check("rst out", bus.out, 0);
    check("rst flags", {bus.zr, bus.ng, bus.co}, 0);
    run_op(MODE_HACK, 16'd5, 16'd3, C_XPLUSY, 1, "x+y");
    run_op(MODE_HACK, 16'd5, 16'd3, C_XMINUSY, 1, "x-y");
    run_op(MODE_HACK, 16'd3, 16'd5, C_XMINUSY, 1, "x-y neg");
    run_op(MODE_HACK, 16'd5, 16'd3, C_ZERO, 1, "zero");
    run_op(MODE_HACK, 16'hFFFF, 16'd1, C_XPLUSY, 1, "carry");
    run_op(MODE_MUL, 16'd300, 16'd300, 6'd0, 1, "mul300");
    run_op(MODE_SRA, 16'h8000, 16'd3, 6'd0, 1, "sra3");
    run_op(MODE_SRA, 16'h8000, 16'd40, 6'd0, 1, "sra40");
    run_op(MODE_SHL, 16'h8000, 16'd0, 6'd0, 1, "shl0");
    run_op(MODE_SHL, 16'h1234, 16'd16, 6'd0, 1, "shl16");
    // result must hold under backpressure; a command offered meanwhile is ignored
    run_op(MODE_MUL, 16'd300, 16'd300, 6'd0, 0, "bp");
    bus.mode = MODE_HACK; bus.x = 16'd1; bus.y = 16'd1; bus.ctrl = C_XPLUSY; bus.in_valid = 1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp out", bus.out, 16'h5F90);
      check("bp out_valid", bus.out_valid, 1);
      check("bp in_ready", bus.in_ready, 0);
    end
    bus.in_valid = 0; bus.out_ready = 1;
    @(posedge clk); #1 bus.out_ready = 0;
    check("bp released", bus.in_ready, 1);
    check("bp no stray", bus.out_valid, 0);
    bus.mode = MODE_MUL; bus.x = 16'd7; bus.y = 16'd9; bus.in_valid = 1;
    @(posedge clk); #1 bus.in_valid = 0;
    repeat (5) @(posedge clk);
    #1 reset = 1;
    @(posedge clk); #1 reset = 0;
    check("midrst in_ready", bus.in_ready, 1);
    check("midrst out_valid", bus.out_valid, 0);
    check("midrst out", bus.out, 0);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen = 1;
    end
    check("midrst no result", seen, 0);
    for (int i = 0; i < 40; i++) begin
      rm = 2'($urandom_range(0, 3));
      rx = 16'($urandom);
      ry = (rm >= 2 && $urandom_range(0, 3) != 0) ? 16'($urandom_range(0, 17)) : 16'($urandom);
      rc = 6'($urandom);
      run_op(rm, rx, ry, rc, 1, "rand");
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
